// File: rtl/conv3x3_mac_if.sv
// Handshake bundle between the conv3x3_mac engine and its parameter/activation feeders.
// The engine takes the slave modport; the producer/consumer side takes master.
interface conv3x3_mac_if #(
  parameter int DAT_W = 22,
  parameter int PAR_W = 16
);
  logic                      start;
  logic [6:0]                n_ch;
  logic signed [PAR_W-1:0]   bias;
  logic                      in_valid;
  logic                      in_ready;
  logic [9*DAT_W-1:0]        win;
  logic [9*PAR_W-1:0]        wgt;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DAT_W-1:0]   out_data;
  logic                      busy;

  modport master (
    output start, n_ch, bias, in_valid, win, wgt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, n_ch, bias, in_valid, win, wgt, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: accumulates n_ch window/weight beats, adds bias, rescales and saturates.
// Optional macro CONV_RELU_EN clamps negative results to zero.
module conv3x3_mac #(
  parameter int DAT_W = 22,
  parameter int PAR_W = 16,
  parameter int FRAC  = 14,
  parameter int ACC_W = 48
) (
  input logic         clk,
  input logic         rst_n,
  conv3x3_mac_if.slave bus
);
  localparam int PROD_W = DAT_W + PAR_W;
  localparam int TREE_W = PROD_W + 4;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINISH, OUT} state_t;

  state_t                   state, state_nx;
  logic [6:0]               n_ch_q;
  logic [6:0]               cnt;
  logic                     drain_q;
  logic                     hs;
  logic signed [PAR_W-1:0]  bias_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod_c  [9];
  logic signed [PROD_W-1:0] prod_p1 [9];
  logic signed [TREE_W-1:0] tree_c;
  logic signed [TREE_W-1:0] tree_p2;
  logic                     vld_p1, vld_p2;
  logic signed [ACC_W-1:0]  t_fin, r_fin;
  logic signed [DAT_W-1:0]  sat_fin, res_fin;

  function automatic logic signed [PROD_W-1:0] mul_tap(input logic signed [DAT_W-1:0] a,
                                                      input logic signed [PAR_W-1:0] w);
    logic signed [PROD_W-1:0] a_x, w_x;
    a_x = {{PAR_W{a[DAT_W-1]}}, a};
    w_x = {{DAT_W{w[PAR_W-1]}}, w};
    return a_x * w_x;
  endfunction

  function automatic logic signed [DAT_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1:DAT_W-1] == {(ACC_W-DAT_W+1){v[ACC_W-1]}})
      return v[DAT_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(DAT_W-1){1'b0}}};
    else
      return {1'b0, {(DAT_W-1){1'b1}}};
  endfunction

`ifdef CONV_RELU_EN
  function automatic logic signed [DAT_W-1:0] relu_fn(input logic signed [DAT_W-1:0] v);
    return v[DAT_W-1] ? '0 : v;
  endfunction
`endif

  assign hs = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.start) state_nx = (bus.n_ch == 7'd0) ? FINISH : ACCUM;
      end
      ACCUM: begin
        bus.in_ready = (cnt < n_ch_q);
        if (hs && (cnt == n_ch_q - 7'd1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_q) state_nx = FINISH;
      end
      FINISH: state_nx = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // stage p1: nine tap products
  always_comb begin
    for (int k = 0; k < 9; k++)
      prod_c[k] = mul_tap(bus.win[k*DAT_W +: DAT_W], bus.wgt[k*PAR_W +: PAR_W]);
  end

  // stage p2: adder tree over sign-extended products
  always_comb begin
    tree_c = '0;
    for (int k = 0; k < 9; k++)
      tree_c = tree_c + {{4{prod_p1[k][PROD_W-1]}}, prod_p1[k]};
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 9; k++) prod_p1[k] <= prod_c[k];
    tree_p2 <= tree_c;
    if (state == IDLE && bus.start) bias_q <= bus.bias;
  end

  // finish: bias in Q(2*FRAC), floor-shift back to Q(FRAC), then clamp
  always_comb begin
    t_fin   = acc + ({{(ACC_W-PAR_W){bias_q[PAR_W-1]}}, bias_q} <<< FRAC);
    r_fin   = t_fin >>> FRAC;
    sat_fin = sat_fn(r_fin);
`ifdef CONV_RELU_EN
    res_fin = relu_fn(sat_fin);
`else
    res_fin = sat_fin;
`endif
  end

  // stage 3: accumulate, counters and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      n_ch_q       <= '0;
      drain_q      <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      acc          <= '0;
      bus.out_data <= '0;
    end else begin
      vld_p1  <= hs;
      vld_p2  <= vld_p1;
      drain_q <= (state == DRAIN) && !drain_q;
      if (state == IDLE && bus.start) begin
        cnt    <= '0;
        n_ch_q <= bus.n_ch;
        acc    <= '0;
      end else begin
        if (hs)     cnt <= cnt + 7'd1;
        if (vld_p2) acc <= acc + {{(ACC_W-TREE_W){tree_p2[TREE_W-1]}}, tree_p2};
      end
      if (state == FINISH) bus.out_data <= res_fin;
    end
  end
endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed, table-driven bench for conv3x3_mac, plus hand-written stall and reset-abort sequences.
module tb_conv3x3_mac;
  localparam int DAT_W = 22;
  localparam int PAR_W = 16;
  localparam int FRAC  = 14;
  localparam int ACC_W = 48;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_mac_if #(.DAT_W(DAT_W), .PAR_W(PAR_W)) bus ();

  conv3x3_mac #(.DAT_W(DAT_W), .PAR_W(PAR_W), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string  tag;
    int     n;
    int     wv;
    int     gv;
    int     b;
    bit     gaps;
    longint expv;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] expv);
    cmp_cnt++;
    if (got !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  function automatic logic [9*DAT_W-1:0] rep_win(input int v);
    logic [9*DAT_W-1:0] r;
    for (int k = 0; k < 9; k++) r[k*DAT_W +: DAT_W] = DAT_W'(v);
    return r;
  endfunction

  function automatic logic [9*PAR_W-1:0] rep_wgt(input int v);
    logic [9*PAR_W-1:0] r;
    for (int k = 0; k < 9; k++) r[k*PAR_W +: PAR_W] = PAR_W'(v);
    return r;
  endfunction

  // One full pixel with out_ready high; bubbles (if any) carry junk window data.
  task automatic run_txn(input string tag, input int n, input int wv, input int gv, input int b,
                         input bit gaps, input longint expv);
    int hs_cyc, rdy_cycles, beats, t, phase;
    bus.start = 1'b1;
    bus.n_ch  = 7'(n);
    bus.bias  = PAR_W'(b);
    hs_cyc    = cyc;
    step();
    bus.start  = 1'b0;
    beats      = 0;
    rdy_cycles = 0;
    phase      = 0;
    t          = 0;
    if (n > 0) chk({tag, "_rdy_first"}, bus.in_ready, 1);
    while (beats < n && t < 200) begin
      bus.in_valid = gaps ? (phase % 2 == 0) : 1'b1;
      bus.win      = bus.in_valid ? rep_win(wv) : rep_win(2097151);
      bus.wgt      = rep_wgt(gv);
      if (bus.in_ready) rdy_cycles++;
      if (bus.in_valid && bus.in_ready) begin
        beats++;
        hs_cyc = cyc;
      end
      phase++;
      t++;
      step();
    end
    bus.in_valid = 1'b0;
    if (n > 0) begin
      chk({tag, "_beats"}, beats, n);
      chk({tag, "_rdy_cycles"}, rdy_cycles, gaps ? 2*n-1 : n);
    end
    t = 0;
    while (!bus.out_valid && t < 20) begin
      step();
      t++;
    end
    chk({tag, "_latency"}, cyc - hs_cyc, (n == 0) ? 2 : 4);
    chk({tag, "_data"}, bus.out_data, expv);
    step();
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    vecs[0] = '{"one",     1,  16384,    16384,  0,      1'b0, 147456};
    vecs[1] = '{"neg",     1,  16384,   -16384,  8192,   1'b0, RELU ? 0 : -139264};
    vecs[2] = '{"sat_pos", 64, 2097151,  32767,  0,      1'b0, 2097151};
    vecs[3] = '{"three",   3,  16384,    16384,  0,      1'b0, 442368};
    vecs[4] = '{"gaps",    3,  16384,    16384,  0,      1'b1, 442368};
    vecs[5] = '{"sat_neg", 2,  -2097152, 32767,  0,      1'b0, RELU ? 0 : -2097152};
    vecs[6] = '{"floor",   1,  1,        -1,     0,      1'b0, RELU ? 0 : -1};
    vecs[7] = '{"bias_neg",1,  16384,    16384,  -16384, 1'b0, 131072};
    vecs[8] = '{"zero_ch", 0,  0,        0,      8192,   1'b0, 8192};

    bus.start     = 1'b0;
    bus.n_ch      = '0;
    bus.bias      = '0;
    bus.in_valid  = 1'b0;
    bus.win       = '0;
    bus.wgt       = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    #1;
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_busy",      bus.busy,      0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    step();

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].tag, vecs[i].n, vecs[i].wv, vecs[i].gv, vecs[i].b, vecs[i].gaps, vecs[i].expv);

    // Result held under back-pressure; a start pulse during OUT must be dropped.
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    bus.n_ch      = 7'd1;
    bus.bias      = '0;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.win      = rep_win(16384);
    bus.wgt      = rep_wgt(16384);
    step();
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      step();
      t++;
    end
    chk("stall_reach", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data",  bus.out_data,  147456);
      chk("stall_busy",  bus.busy,      1);
      bus.start = (i == 2);
      bus.n_ch  = 7'd0;
      bus.bias  = 16'sd100;
      step();
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("stall_release_busy",  bus.busy,      0);
    chk("stall_release_valid", bus.out_valid, 0);
    step();
    chk("stall_start_ignored", bus.busy, 0);

    // Abort mid-accumulation, then a clean bias-only pixel.
    bus.start = 1'b1;
    bus.n_ch  = 7'd5;
    bus.bias  = 16'sd1000;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.win      = rep_win(100000);
    bus.wgt      = rep_wgt(5000);
    step();
    step();
    chk("abort_pre_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  bus.in_ready,  0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data",  bus.out_data,  0);
    chk("abort_busy",      bus.busy,      0);
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_txn("after_rst", 0, 0, 0, 8192, 1'b0, 8192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
